// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch address, reads im one word per cycle,
// buffers {addr, word} pairs in a DEPTH-entry FIFO and redirects on flush.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_f,
    input  logic                     flush,
    input  logic [AW-1:0]            flush_addr,
    output logic [AW-1:0]            im_addr,
    input  logic [DW-1:0]            im_data,
    input  logic                     pop,
    output logic [DW-1:0]            instr_out,
    output logic [AW-1:0]            instr_addr,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [AW-1:0] fetch_ptr;

    logic          do_pop;
    logic          do_push;
    logic [PW-1:0] head_n;
    logic [PW-1:0] tail_n;
    logic [CW-1:0] count_n;
    logic [CW-1:0] count_after_pop;
    logic [AW-1:0] fetch_ptr_n;
    logic [DW-1:0] instr_out_n;
    logic [AW-1:0] instr_addr_n;

    assign im_addr = fetch_ptr;

    // Next pointer/count state plus the head entry the output registers will show next cycle
    always_comb begin
        do_pop          = pop & valid & ~flush;
        do_push         = ~flush & (~full | do_pop);
        head_n          = head;
        tail_n          = tail;
        count_n         = count;
        fetch_ptr_n     = fetch_ptr;
        count_after_pop = count - CW'(do_pop);
        instr_out_n     = '0;
        instr_addr_n    = '0;

        if (flush) begin
            head_n      = '0;
            tail_n      = '0;
            count_n     = '0;
            fetch_ptr_n = flush_addr;
        end else begin
            if (do_push) begin
                tail_n      = tail + PW'(1);
                fetch_ptr_n = fetch_ptr + AW'(1);
            end
            if (do_pop) begin
                head_n = head + PW'(1);
            end
            count_n = count + CW'(do_push) - CW'(do_pop);
        end

        // A word pushed into an otherwise empty queue becomes the head directly
        if (count_n != '0) begin
            if (do_push && (count_after_pop == '0)) begin
                instr_out_n  = im_data;
                instr_addr_n = fetch_ptr;
            end else begin
                instr_out_n  = data_mem[head_n];
                instr_addr_n = addr_mem[head_n];
            end
        end
    end

    // Pointer, count and output registers
    always_ff @(posedge clk) begin
        if (rst_f) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            fetch_ptr  <= '0;
            valid      <= 1'b0;
            full       <= 1'b0;
            instr_out  <= '0;
            instr_addr <= '0;
        end else begin
            head       <= head_n;
            tail       <= tail_n;
            count      <= count_n;
            fetch_ptr  <= fetch_ptr_n;
            valid      <= (count_n != '0);
            full       <= (count_n == CW'(DEPTH));
            instr_out  <= instr_out_n;
            instr_addr <= instr_addr_n;
        end
    end

    // Entry storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (!rst_f && do_push) begin
            addr_mem[tail] <= fetch_ptr;
            data_mem[tail] <= im_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table plus randomized run
// against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_f;
    logic        flush;
    logic [15:0] flush_addr;
    logic [15:0] im_addr;
    logic [31:0] im_data;
    logic        pop;
    logic [31:0] instr_out;
    logic [15:0] instr_addr;
    logic        valid;
    logic        full;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .AW(16), .DW(32)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .flush      (flush),
        .flush_addr (flush_addr),
        .im_addr    (im_addr),
        .im_data    (im_data),
        .pop        (pop),
        .instr_out  (instr_out),
        .instr_addr (instr_addr),
        .valid      (valid),
        .full       (full),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [15:0] a);
        return 32'hA000_0000 + {16'h0000, a};
    endfunction

    assign im_data = im_word(im_addr);

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a plain queue of fetched {addr, word} pairs and a fetch address
    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mfp;

    task automatic model_update(input logic r, input logic f, input logic [15:0] fa, input logic p);
        ent_t e;
        if (r) begin
            mq.delete();
            mfp = 16'h0000;
        end else if (f) begin
            mq.delete();
            mfp = fa;
        end else begin
            if (p && mq.size() > 0) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                e.a = mfp;
                e.d = im_word(mfp);
                mq.push_back(e);
                mfp = mfp + 16'h0001;
            end
        end
    endtask

    task automatic step(input logic r, input logic f, input logic [15:0] fa, input logic p);
        rst_f      = r;
        flush      = f;
        flush_addr = fa;
        pop        = p;
        model_update(r, f, fa, p);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int cyc);
        logic [31:0] e_out;
        logic [15:0] e_addr;
        e_out  = (mq.size() != 0) ? mq[0].d : 32'h0;
        e_addr = (mq.size() != 0) ? mq[0].a : 16'h0;
        chk($sformatf("rnd%0d count", cyc), 32'(count), 32'(mq.size()));
        chk($sformatf("rnd%0d valid", cyc), 32'(valid), 32'(mq.size() != 0));
        chk($sformatf("rnd%0d full", cyc), 32'(full), 32'(mq.size() == DEPTH));
        chk($sformatf("rnd%0d im_addr", cyc), 32'(im_addr), 32'(mfp));
        chk($sformatf("rnd%0d instr_addr", cyc), 32'(instr_addr), 32'(e_addr));
        chk($sformatf("rnd%0d instr_out", cyc), instr_out, e_out);
    endtask

    // Directed vectors: inputs for one cycle and the state expected after that edge
    typedef struct {
        logic        r;
        logic        f;
        logic [15:0] fa;
        logic        p;
        int          cnt;
        logic [15:0] head;
        logic [15:0] ima;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic r, input logic f, input logic [15:0] fa, input logic p,
                                input int cnt, input logic [15:0] head, input logic [15:0] ima);
        vec_t v;
        v.r = r; v.f = f; v.fa = fa; v.p = p;
        v.cnt = cnt; v.head = head; v.ima = ima;
        return v;
    endfunction

    initial begin
        int          pop_pct;
        logic        r;
        logic        f;
        logic        p;
        logic [15:0] fa;
        logic [31:0] e_out;

        rst_f = 1'b1; flush = 1'b0; flush_addr = 16'h0; pop = 1'b0;

        // reset and fill
        tbl[0]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        tbl[1]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        tbl[2]  = mk(0, 0, 16'h0000, 0, 1, 16'h0000, 16'h0001);
        tbl[3]  = mk(0, 0, 16'h0000, 0, 2, 16'h0000, 16'h0002);
        tbl[4]  = mk(0, 0, 16'h0000, 0, 3, 16'h0000, 16'h0003);
        tbl[5]  = mk(0, 0, 16'h0000, 0, 4, 16'h0000, 16'h0004);
        tbl[6]  = mk(0, 0, 16'h0000, 0, 4, 16'h0000, 16'h0004);
        // drain while full: push and pop coincide
        tbl[7]  = mk(0, 0, 16'h0000, 1, 4, 16'h0001, 16'h0005);
        tbl[8]  = mk(0, 0, 16'h0000, 1, 4, 16'h0002, 16'h0006);
        tbl[9]  = mk(0, 0, 16'h0000, 1, 4, 16'h0003, 16'h0007);
        // flush with pop held; pop on empty is ignored
        tbl[10] = mk(0, 1, 16'h0010, 1, 0, 16'h0000, 16'h0010);
        tbl[11] = mk(0, 0, 16'h0000, 1, 1, 16'h0010, 16'h0011);
        tbl[12] = mk(0, 0, 16'h0000, 1, 1, 16'h0011, 16'h0012);
        tbl[13] = mk(0, 0, 16'h0000, 0, 2, 16'h0011, 16'h0013);
        tbl[14] = mk(0, 0, 16'h0000, 0, 3, 16'h0011, 16'h0014);
        // flush mid-stream with pop
        tbl[15] = mk(0, 1, 16'h0040, 1, 0, 16'h0000, 16'h0040);
        tbl[16] = mk(0, 0, 16'h0000, 0, 1, 16'h0040, 16'h0041);
        // address wrap
        tbl[17] = mk(0, 1, 16'hFFFE, 0, 0, 16'h0000, 16'hFFFE);
        tbl[18] = mk(0, 0, 16'h0000, 1, 1, 16'hFFFE, 16'hFFFF);
        tbl[19] = mk(0, 0, 16'h0000, 1, 1, 16'hFFFF, 16'h0000);
        tbl[20] = mk(0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0001);
        tbl[21] = mk(0, 0, 16'h0000, 1, 1, 16'h0001, 16'h0002);
        tbl[22] = mk(0, 0, 16'h0000, 0, 2, 16'h0001, 16'h0003);
        tbl[23] = mk(0, 0, 16'h0000, 0, 3, 16'h0001, 16'h0004);
        tbl[24] = mk(0, 0, 16'h0000, 0, 4, 16'h0001, 16'h0005);
        // reset beats flush and pop
        tbl[25] = mk(1, 1, 16'h0077, 1, 0, 16'h0000, 16'h0000);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].fa, tbl[i].p);
            e_out = (tbl[i].cnt != 0) ? im_word(tbl[i].head) : 32'h0;
            chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d valid", i), 32'(valid), 32'(tbl[i].cnt != 0));
            chk($sformatf("vec%0d full", i), 32'(full), 32'(tbl[i].cnt == DEPTH));
            chk($sformatf("vec%0d im_addr", i), 32'(im_addr), 32'(tbl[i].ima));
            chk($sformatf("vec%0d instr_addr", i), 32'(instr_addr), 32'(tbl[i].head));
            chk($sformatf("vec%0d instr_out", i), instr_out, e_out);
        end

        // Hand sequence: fill, then 6 back-to-back pops must give consecutive addresses
        step(1, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("drain%0d instr_out", i), instr_out, 32'hA000_0000 + 32'(i));
            chk($sformatf("drain%0d count", i), 32'(count), 32'd4);
            step(0, 0, 16'h0, 1);
        end

        // Randomized run against the model, pop pressure varied per phase
        pop_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) pop_pct = $urandom_range(0, 100);
            r  = ($urandom_range(0, 99) < 2);
            f  = ($urandom_range(0, 99) < 6);
            fa = ($urandom_range(0, 3) == 0) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                             : 16'($urandom);
            p  = ($urandom_range(0, 99) < pop_pct);
            step(r, f, fa, p);
            check_model(i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
